// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, response causes,
// sequencing states and small access-decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_OK    = 2'b00;
    localparam logic [1:0] CAUSE_BADF3 = 2'b01;
    localparam logic [1:0] CAUSE_MISAL = 2'b10;
    localparam logic [1:0] CAUSE_RANGE = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        LD_LO,
        LD_HI,
        ST_BYTE,
        ERR,
        RESP
    } lsu_state_e;

    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic bad_func3(input logic store, input logic [2:0] f3);
        if (store) return f3[2] || (f3 == 3'b011);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_load_merge.sv
// Assembles a misaligned load from two consecutive aligned words, then truncates
// and extends the result according to funct3.
module lsu_load_merge
    import lsu_pkg::*;
(
    input  logic [31:0] lo_i,
    input  logic [23:0] hi_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  func3_i,
    output logic [31:0] data_o
);

    logic [31:0] win;

    // The top byte of the high word can never belong to an access of at most 4 bytes.
    always_comb begin
        case (offset_i)
            2'd0:    win = lo_i;
            2'd1:    win = {hi_i[7:0],  lo_i[31:8]};
            2'd2:    win = {hi_i[15:0], lo_i[31:16]};
            default: win = {hi_i[23:0], lo_i[31:24]};
        endcase
    end

    always_comb begin
        case (func3_i)
            F3_B:    data_o = {{24{win[7]}}, win[7:0]};
            F3_H:    data_o = {{16{win[15]}}, win[15:0]};
            F3_BU:   data_o = {24'b0, win[7:0]};
            F3_HU:   data_o = {16'b0, win[15:0]};
            default: data_o = win;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: one request in flight, single-cycle aligned accesses,
// misaligned loads as two word reads plus merge, misaligned stores as byte writes.
//
//   state   | meaning
//   IDLE    | ready for a request
//   ACCESS  | single aligned memory cycle
//   LD_LO   | misaligned load, reading the lower word
//   LD_HI   | misaligned load, reading the upper word and merging
//   ST_BYTE | misaligned store, one SB per cycle
//   ERR     | error response presented, no memory cycle
//   RESP    | response held until consumed
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES        = 1024,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_base,
    input  logic [11:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  rsp_cause,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [2:0]  mem_func3,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic [31:0] ea_q, ea_d, wdata_q, wdata_d, lo_q, lo_d, rdata_q, rdata_d;
    logic [2:0]  func3_q, func3_d;
    logic        store_q, store_d, err_q, err_d;
    logic [1:0]  k_q, k_d, cause_q, cause_d;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [2:0]  mem_func3_q;

    logic [31:0] ea_in, word_addr, merged;
    logic [2:0]  size_in, size_m1;
    logic [32:0] last_in;
    logic        bad_in, range_in, misal_in;

    assign ea_in     = req_base + {{20{req_offset[11]}}, req_offset};
    assign size_in   = access_size(req_func3);
    assign last_in   = {1'b0, ea_in} + {30'b0, size_in} - 33'd1;
    assign bad_in    = bad_func3(req_store, req_func3);
    assign range_in  = last_in[32] || (last_in[31:0] >= 32'(MEM_BYTES));
    assign misal_in  = ((size_in == 3'd2) && ea_in[0]) ||
                       ((size_in == 3'd4) && (ea_in[1:0] != 2'b00));
    assign size_m1   = access_size(func3_q) - 3'd1;
    assign word_addr = {ea_q[31:2], 2'b00};

    lsu_load_merge u_merge (
        .lo_i     (lo_q),
        .hi_i     (mem_rdata[23:0]),
        .offset_i (ea_q[1:0]),
        .func3_i  (func3_q),
        .data_o   (merged)
    );

    // Memory port is decoded from state so reset drops mem_we at once; address/data hold otherwise.
    always_comb begin
        mem_addr  = mem_addr_q;
        mem_func3 = mem_func3_q;
        mem_wdata = mem_wdata_q;
        mem_we    = 1'b0;
        case (state_q)
            ACCESS: begin
                mem_addr  = ea_q;
                mem_func3 = func3_q;
                mem_wdata = wdata_q;
                mem_we    = store_q;
            end
            LD_LO: begin
                mem_addr  = word_addr;
                mem_func3 = F3_W;
            end
            LD_HI: begin
                mem_addr  = word_addr + 32'd4;
                mem_func3 = F3_W;
            end
            ST_BYTE: begin
                mem_addr  = ea_q + {30'b0, k_q};
                mem_func3 = F3_B;
                mem_wdata = {24'b0, wdata_q[{k_q, 3'b000} +: 8]};
                mem_we    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ea_d    = ea_q;
        func3_d = func3_q;
        store_d = store_q;
        wdata_d = wdata_q;
        k_d     = k_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ea_d    = ea_in;
                    func3_d = req_func3;
                    store_d = req_store;
                    wdata_d = req_wdata;
                    k_d     = 2'd0;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    cause_d = CAUSE_OK;
                    if (bad_in) begin
                        err_d = 1'b1; cause_d = CAUSE_BADF3; state_d = ERR;
                    end else if (range_in) begin
                        err_d = 1'b1; cause_d = CAUSE_RANGE; state_d = ERR;
                    end else if (misal_in && !ALLOW_MISALIGNED) begin
                        err_d = 1'b1; cause_d = CAUSE_MISAL; state_d = ERR;
                    end else if (misal_in) begin
                        state_d = req_store ? ST_BYTE : LD_LO;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!store_q) rdata_d = mem_rdata;
                state_d = RESP;
            end
            LD_LO: begin
                lo_d    = mem_rdata;
                state_d = LD_HI;
            end
            LD_HI: begin
                rdata_d = merged;
                state_d = RESP;
            end
            ST_BYTE: begin
                if ({1'b0, k_q} == size_m1) state_d = RESP;
                else                        k_d     = k_q + 2'd1;
            end
            // The error response is already visible here, saving a cycle.
            ERR:  state_d = rsp_ready ? IDLE : RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ea_q        <= '0;
            func3_q     <= '0;
            store_q     <= 1'b0;
            wdata_q     <= '0;
            k_q         <= '0;
            lo_q        <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cause_q     <= CAUSE_OK;
            mem_addr_q  <= '0;
            mem_func3_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ea_q        <= ea_d;
            func3_q     <= func3_d;
            store_q     <= store_d;
            wdata_q     <= wdata_d;
            k_q         <= k_d;
            lo_q        <= lo_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cause_q     <= cause_d;
            mem_addr_q  <= mem_addr;
            mem_func3_q <= mem_func3;
            mem_wdata_q <= mem_wdata;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP) || (state_q == ERR);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign rsp_cause = cause_q;

endmodule
